cdc_sync_filter: RTL and testbench
==================================

// Module: cdc_sync_filter
// PURPOSE
//  Multi-channel input synchronizer with per-channel glitch filter, edge pulses and sticky change flags.
//  Each asynchronous level input passes a RANK-deep synchronizer, then a stability counter.
//  The filtered output updates only after FILTER_CYCLES consecutive cycles of disagreement.
//  Sits at chip-level async inputs (straps, external IRQ/status pins) feeding the control plane.
// PARAMETERS
//  CHANNELS      4    number of independent 1-bit channels
//  RANK          2    synchronizer depth, legal 2..4 (fatal at elaboration otherwise)
//  FILTER_CYCLES 3    consecutive mismatching cycles before o updates; legal >=1 (1 = no filtering)
//  RAND          1    sim-only: randomize the first flop when its input changes; ignored under SYNTHESIS/FPGA
//  RESET_VALUE   '0   [CHANNELS-1:0] reset value of sync flops and o
// PORTS
//  clk_i    in   1         clock
//  rst_i    in   1         reset, asynchronous, active-high
//  i        in   CHANNELS  async level inputs
//  clr_i    in   CHANNELS  per-channel clear of chg_o (synchronous to clk_i)
//  o        out  CHANNELS  filtered, synchronized level
//  rise_o   out  CHANNELS  1-cycle pulse, o went 0->1
//  fall_o   out  CHANNELS  1-cycle pulse, o went 1->0
//  chg_o    out  CHANNELS  sticky: set on any o change, cleared by clr_i
// BEHAVIOUR
//  - Reset: sync flops=RESET_VALUE, o=RESET_VALUE, counters=0, rise_o=fall_o=chg_o=0; no pulse on release.
//  - All outputs are registered; no combinational path from i or clr_i to any output.
//  - Sync stage: first flop carries the cdc_ prefix; s[c] = last flop of the RANK chain.
//  - Filter, per channel, each clk_i edge:
//    s==o             -> cnt<=0
//    s!=o, cnt<F-1    -> cnt<=cnt+1
//    s!=o, cnt==F-1   -> o<=s, cnt<=0
//    cnt width $clog2(FILTER_CYCLES); clamped to 1 bit minimum.
//  - Latency (RAND=0): a stable change on i appears on o at the (RANK+FILTER_CYCLES)th rising edge after it.
//    With RAND=1 add 0..1 cycle.
//  - Glitch: any return s==o before cnt reaches F-1 clears cnt.
//    Repeated short pulses never accumulate; o and pulses stay unchanged.
//  - rise_o/fall_o: asserted in exactly the cycle in which the new o value is first visible.
//    Never both high on one channel; back-to-back opposite edges are impossible when FILTER_CYCLES>=2.
//  - chg_o: set on the edge o changes; clr_i clears it.
//    Same-cycle clr_i and o change -> set wins (chg_o stays 1).
//    clr_i with no change -> chg_o=0 next cycle.
//  - Reset mid-count: everything returns to its reset value immediately (async).
//    After release a full RANK+FILTER_CYCLES is required again.
//  - Channels are fully independent; no cross-channel ordering guarantee (not for multi-bit buses).
// STRUCTURE
//  - Package cdc_pkg: localparams CDC_RANK_MIN=2, CDC_RANK_MAX=4; function cdc_cnt_w(int f) returning the counter width.
//  - Sub-module glitch_filter_ch (one instance per channel, generate loop).
//    Holds cnt, o, rise, fall and chg for one bit; top owns the synchronizer array and RAND model.
//  - Elaboration assertions: RANK in range, FILTER_CYCLES>=1.
// TESTING (CHANNELS=4, RANK=2, FILTER_CYCLES=3, RAND=0 unless noted)
//  1 RESET_VALUE=4'b0101, i=4'b0101 through rst_i release -> o=0101; rise/fall/chg all 0 for 10 cycles.
//  2 i[0] 0->1 held -> o[0]=1 at 5th edge; rise_o[0] high exactly 1 cycle; chg_o[0]=1 until cleared.
//  3 i[1] high for 2 cycles then low -> o[1] stays 0; no rise_o/fall_o; chg_o[1]=0.
//  4 i[2] high 2, low 1, high held -> one rise_o[2], 5 edges after the final 0->1 edge.
//  5 clr_i[3] asserted on the rise edge of o[3] -> chg_o[3]=1; clr_i[3] again next cycle -> chg_o[3]=0.
//  6 rst_i pulsed while cnt[0]=2 -> o returns to RESET_VALUE; after release the full 5-edge latency is needed again.
//  7 FILTER_CYCLES=1, RAND=1 -> o follows i in 3..4 edges; random toggling of i never gives rise&fall together.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared limits and helpers for the synchronizer/filter slice.
package cdc_pkg;

    localparam int CDC_RANK_MIN = 2;
    localparam int CDC_RANK_MAX = 4;

    // Stability counter width; a filter of 1 or 2 cycles still gets one bit.
    function automatic int cdc_cnt_w(input int f);
        return (f <= 2) ? 1 : $clog2(f);
    endfunction

endpackage

// File: rtl/glitch_filter_ch.sv
// One-bit stability filter: the output follows the synchronized input only after
// FILTER_CYCLES consecutive cycles of disagreement, with edge pulses and a sticky change flag.
module glitch_filter_ch
    import cdc_pkg::*;
#(
    parameter int   FILTER_CYCLES = 3,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic s_i,
    input  logic clr_i,
    output logic o,
    output logic rise_o,
    output logic fall_o,
    output logic chg_o
);

    localparam int             CW       = cdc_cnt_w(FILTER_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          o_q, o_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          chg_q, chg_d;
    logic          upd;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        o_d   = o_q;
        if (s_i == o_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            o_d   = s_i;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        upd    = (o_d != o_q);
        rise_d = upd & o_d;
        fall_d = upd & ~o_d;
        // A change in the same cycle as a clear keeps the flag set.
        chg_d  = upd | (chg_q & ~clr_i);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            o_q    <= RESET_VALUE;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            chg_q  <= chg_d;
        end
    end

    assign o      = o_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/cdc_sync_filter.sv
// Multi-channel async level-input synchronizer feeding one glitch filter per channel.
// The top owns the RANK-deep synchronizer chain and the simulation-only metastability model.
module cdc_sync_filter
    import cdc_pkg::*;
#(
    parameter int                  CHANNELS      = 4,
    parameter int                  RANK          = 2,
    parameter int                  FILTER_CYCLES = 3,
    parameter int                  RAND          = 1,
    parameter logic [CHANNELS-1:0] RESET_VALUE   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] i,
    input  logic [CHANNELS-1:0] clr_i,
    output logic [CHANNELS-1:0] o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] chg_o
);

    if (RANK < CDC_RANK_MIN || RANK > CDC_RANK_MAX) begin : g_rank_check
        $fatal(1, "cdc_sync_filter: RANK must be within 2..4");
    end
    if (FILTER_CYCLES < 1) begin : g_filter_check
        $fatal(1, "cdc_sync_filter: FILTER_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0]            cdc_sync_q, cdc_sync_d;
    logic [CHANNELS-1:0]            in_last_q;
    logic [CHANNELS-1:0]            meta_hold;
    logic [RANK-2:0][CHANNELS-1:0]  sync_pipe_q;
    logic [CHANNELS-1:0]            s;

`ifdef SYNTHESIS
    assign meta_hold = '0;
`elsif FPGA
    assign meta_hold = '0;
`else
    // Models metastability resolution: a freshly changed input may be caught one cycle late.
    logic [CHANNELS-1:0] rnd_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rnd_q <= '0;
        else       rnd_q <= CHANNELS'($urandom);
    end
    assign meta_hold = (RAND != 0) ? rnd_q : '0;
`endif

    assign cdc_sync_d = i ^ (meta_hold & (i ^ in_last_q));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cdc_sync_q  <= RESET_VALUE;
            in_last_q   <= RESET_VALUE;
            sync_pipe_q <= {(RANK-1){RESET_VALUE}};
        end else begin
            cdc_sync_q     <= cdc_sync_d;
            in_last_q      <= i;
            sync_pipe_q[0] <= cdc_sync_q;
            for (int k = 1; k < RANK - 1; k++) begin
                sync_pipe_q[k] <= sync_pipe_q[k-1];
            end
        end
    end

    assign s = sync_pipe_q[RANK-2];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        glitch_filter_ch #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_VALUE   (RESET_VALUE[c])
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .s_i    (s[c]),
            .clr_i  (clr_i[c]),
            .o      (o[c]),
            .rise_o (rise_o[c]),
            .fall_o (fall_o[c]),
            .chg_o  (chg_o[c])
        );
    end

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter: three instances cover reset value, filtering and the RAND model.
module tb_cdc_sync_filter;

    logic       clk;
    logic       rst;
    logic [3:0] i_a, clr_a, o_a, rise_a, fall_a, chg_a;
    logic [3:0] i_b, clr_b, o_b, rise_b, fall_b, chg_b;
    logic [3:0] i_c, clr_c, o_c, rise_c, fall_c, chg_c;

    int n_checks;
    int n_fail;

    cdc_sync_filter #(
        .CHANNELS(4), .RANK(2), .FILTER_CYCLES(3), .RAND(0), .RESET_VALUE(4'b0101)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .i(i_a), .clr_i(clr_a),
        .o(o_a), .rise_o(rise_a), .fall_o(fall_a), .chg_o(chg_a)
    );

    cdc_sync_filter #(
        .CHANNELS(4), .RANK(2), .FILTER_CYCLES(3), .RAND(0), .RESET_VALUE(4'b0000)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .i(i_b), .clr_i(clr_b),
        .o(o_b), .rise_o(rise_b), .fall_o(fall_b), .chg_o(chg_b)
    );

    cdc_sync_filter #(
        .CHANNELS(4), .RANK(2), .FILTER_CYCLES(1), .RAND(1), .RESET_VALUE(4'b0000)
    ) dut_c (
        .clk_i(clk), .rst_i(rst), .i(i_c), .clr_i(clr_c),
        .o(o_c), .rise_o(rise_c), .fall_o(fall_c), .chg_o(chg_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_a = 4'b0101; clr_a = '0;
        i_b = 4'b0000; clr_b = '0;
        i_c = 4'b0000; clr_c = '0;
        repeat (3) tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (o_a !== 4'b0101) begin
                n_fail++;
                $display("FAIL reset_o_a cycle %0d: got %b expected 0101", k, o_a);
            end
            n_checks++;
            if ({rise_a, fall_a, chg_a} !== 12'b0) begin
                n_fail++;
                $display("FAIL reset_flags_a cycle %0d: got %b expected 0", k, {rise_a, fall_a, chg_a});
            end
        end
        n_checks++;
        if ({o_b, rise_b, fall_b, chg_b} !== 16'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %b expected 0", {o_b, rise_b, fall_b, chg_b});
        end
    endtask

    task automatic test_rise();
        i_b[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if (o_b[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rise_early edge %0d: got %b expected 0", k, o_b[0]);
            end
        end
        tick();
        n_checks++;
        if ({o_b[0], rise_b[0], fall_b[0], chg_b[0]} !== 4'b1101) begin
            n_fail++;
            $display("FAIL rise_edge5 o/rise/fall/chg: got %b expected 1101",
                     {o_b[0], rise_b[0], fall_b[0], chg_b[0]});
        end
        tick();
        n_checks++;
        if ({o_b[0], rise_b[0], chg_b[0]} !== 3'b101) begin
            n_fail++;
            $display("FAIL rise_after o/rise/chg: got %b expected 101", {o_b[0], rise_b[0], chg_b[0]});
        end
        clr_b[0] = 1'b1;
        tick();
        clr_b[0] = 1'b0;
        n_checks++;
        if ({o_b[0], chg_b[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL rise_clear o/chg: got %b expected 10", {o_b[0], chg_b[0]});
        end
    endtask

    task automatic test_glitch();
        bit pattern [12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
        for (int k = 0; k < 22; k++) begin
            i_b[1] = (k < 12) ? pattern[k] : 1'b0;
            tick();
            n_checks++;
            if ({o_b[1], rise_b[1], fall_b[1], chg_b[1]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL glitch cycle %0d o/rise/fall/chg: got %b expected 0000",
                         k, {o_b[1], rise_b[1], fall_b[1], chg_b[1]});
            end
        end
    endtask

    task automatic test_glitch_recover();
        i_b[2] = 1'b1; tick();
        tick();
        i_b[2] = 1'b0; tick();
        i_b[2] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if ({o_b[2], rise_b[2]} !== 2'b00) begin
                n_fail++;
                $display("FAIL recover_early edge %0d o/rise: got %b expected 00", k, {o_b[2], rise_b[2]});
            end
        end
        tick();
        n_checks++;
        if ({o_b[2], rise_b[2], fall_b[2]} !== 3'b110) begin
            n_fail++;
            $display("FAIL recover_edge5 o/rise/fall: got %b expected 110", {o_b[2], rise_b[2], fall_b[2]});
        end
        tick();
        n_checks++;
        if ({o_b[2], rise_b[2]} !== 2'b10) begin
            n_fail++;
            $display("FAIL recover_after o/rise: got %b expected 10", {o_b[2], rise_b[2]});
        end
    endtask

    task automatic test_clr_priority();
        i_b[3] = 1'b1;
        repeat (4) tick();
        clr_b[3] = 1'b1;
        tick();
        n_checks++;
        if ({o_b[3], rise_b[3], chg_b[3]} !== 3'b111) begin
            n_fail++;
            $display("FAIL clr_vs_set o/rise/chg: got %b expected 111", {o_b[3], rise_b[3], chg_b[3]});
        end
        tick();
        clr_b[3] = 1'b0;
        n_checks++;
        if ({o_b[3], chg_b[3]} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_second o/chg: got %b expected 10", {o_b[3], chg_b[3]});
        end
    endtask

    task automatic test_fall();
        i_b[0] = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (o_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL fall_early: got %b expected 1", o_b[0]);
        end
        tick();
        n_checks++;
        if ({o_b[0], rise_b[0], fall_b[0], chg_b[0]} !== 4'b0011) begin
            n_fail++;
            $display("FAIL fall_edge5 o/rise/fall/chg: got %b expected 0011",
                     {o_b[0], rise_b[0], fall_b[0], chg_b[0]});
        end
        tick();
        n_checks++;
        if (fall_b[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_after: got %b expected 0", fall_b[0]);
        end
    endtask

    task automatic test_reset_mid_count();
        i_b[0] = 1'b1;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_b, rise_b, fall_b, chg_b} !== 16'b0) begin
            n_fail++;
            $display("FAIL midrst_async o/rise/fall/chg: got %b expected 0", {o_b, rise_b, fall_b, chg_b});
        end
        n_checks++;
        if ({o_a, chg_a} !== 8'b0101_0000) begin
            n_fail++;
            $display("FAIL midrst_a o/chg: got %b expected 01010000", {o_a, chg_a});
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++;
            if ({o_b, rise_b} !== 8'b0) begin
                n_fail++;
                $display("FAIL midrst_relaunch edge %0d o/rise: got %b expected 0", k, {o_b, rise_b});
            end
        end
        tick();
        n_checks++;
        if ({o_b, rise_b, fall_b} !== 12'b1101_1101_0000) begin
            n_fail++;
            $display("FAIL midrst_edge5 o/rise/fall: got %b expected 110111010000", {o_b, rise_b, fall_b});
        end
    endtask

    task automatic test_rand_filter1();
        logic [3:0] prev_o;
        int         rises;
        i_c[0] = 1'b1;
        repeat (2) tick();
        n_checks++;
        if (o_c[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_early: got %b expected 0", o_c[0]);
        end
        rises = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (rise_c[0] === 1'b1) rises++;
        end
        n_checks++;
        if (o_c[0] !== 1'b1 || rises != 1) begin
            n_fail++;
            $display("FAIL rand_latency o/rises: got %b/%0d expected 1/1", o_c[0], rises);
        end
        prev_o = o_c;
        for (int k = 0; k < 300; k++) begin
            i_c = 4'($urandom);
            tick();
            n_checks++;
            if ((rise_c & fall_c) !== 4'b0) begin
                n_fail++;
                $display("FAIL rand_both cycle %0d: got %b expected 0000", k, rise_c & fall_c);
            end
            n_checks++;
            if ({rise_c, fall_c} !== {o_c & ~prev_o, ~o_c & prev_o}) begin
                n_fail++;
                $display("FAIL rand_edges cycle %0d rise/fall: got %b expected %b",
                         k, {rise_c, fall_c}, {o_c & ~prev_o, ~o_c & prev_o});
            end
            prev_o = o_c;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_rise();
        test_glitch();
        test_glitch_recover();
        test_clr_priority();
        test_fall();
        test_reset_mid_count();
        test_rand_filter1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
